// File: rtl/spi_upload_pkg.sv
// Shared definitions for the SPI upload transmitter: FSM states and the
// data_io command bytes.
package spi_upload_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StIdx,
    StTx,
    StSkip
  } state_e;

  localparam logic [7:0] CmdIndex = 8'h54;
  localparam logic [7:0] CmdStart = 8'h55;
  localparam logic [7:0] CmdData  = 8'h56;
  localparam logic [7:0] CmdEnd   = 8'h57;

endpackage

// File: rtl/spi_upload_tx_if.sv
// Core-side memory read bus used by the upload transmitter.
interface spi_upload_tx_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;

  modport master (
    output ioctl_upload,
    output ioctl_index,
    output ioctl_addr,
    output ioctl_rd,
    input  ioctl_din
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_index,
    input  ioctl_addr,
    input  ioctl_rd,
    output ioctl_din
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous SPI pin,
// producing the synchronised level and single-cycle rise/fall pulses.
module spi_pin_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pin_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_upload_tx.sv
// SPI-slave transmitter for core-to-MCU uploads: decodes MCU commands and
// streams core memory bytes out on MISO (mode 0, MSB first).
module spi_upload_tx
  import spi_upload_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  CMD_INDEX = CmdIndex,
  parameter logic [7:0]  CMD_START = CmdStart,
  parameter logic [7:0]  CMD_DATA  = CmdData,
  parameter logic [7:0]  CMD_END   = CmdEnd
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            SPI_SCK,
  input  logic            SPI_SS2,
  input  logic            SPI_DI,
  output logic            spi_do,
  output logic            spi_do_oe,
  spi_upload_tx_if.master ioctl
);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic di_lvl, di_rise, di_fall;

  spi_pin_sync #(.ResetVal(1'b0)) u_sync_sck (
    .clk_i(clk_sys), .rst_i(reset), .pin_i(SPI_SCK),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_pin_sync #(.ResetVal(1'b1)) u_sync_ss (
    .clk_i(clk_sys), .rst_i(reset), .pin_i(SPI_SS2),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_pin_sync #(.ResetVal(1'b0)) u_sync_di (
    .clk_i(clk_sys), .rst_i(reset), .pin_i(SPI_DI),
    .level_o(di_lvl), .rise_o(di_rise), .fall_o(di_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, ss_rise, ss_fall, di_rise, di_fall};

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [7:0]        prefetch_q, prefetch_d;
  logic              rd_q, rd_d;
  logic              rd_dly_q, rd_dly_d;
  logic              upload_q, upload_d;
  logic [7:0]        index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rx_byte;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    upload_d   = upload_q;
    index_d    = index_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    rd_dly_d   = rd_q;
    prefetch_d = rd_dly_q ? ioctl.ioctl_din : prefetch_q;
    rx_byte    = {rx_sr_q[6:0], di_lvl};

    // SS high wins over any same-cycle SCK edge
    if (ss_lvl) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      rx_sr_d   = 8'h00;
      tx_sr_d   = 8'h00;
    end else if (state_q == StIdle) begin
      state_d   = StCmd;
      bit_cnt_d = 3'd0;
      rx_sr_d   = 8'h00;
    end else begin
      if (sck_rise) begin
        rx_sr_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              state_d = StSkip;
              if (rx_byte == CMD_INDEX) begin
                state_d = StIdx;
              end else if (rx_byte == CMD_START) begin
                upload_d = 1'b1;
                addr_d   = '0;
              end else if (rx_byte == CMD_END) begin
                upload_d = 1'b0;
              end else if (rx_byte == CMD_DATA) begin
                state_d = StTx;
                rd_d    = 1'b1;
              end
            end
            StIdx: begin
              index_d = rx_byte;
              state_d = StSkip;
            end
            StTx:    rd_d = 1'b1;
            default: ;
          endcase
        end
      end
      // Bit 0 fall loads the prefetched byte; the address advances per loaded byte
      if (sck_fall && state_q == StTx) begin
        if (bit_cnt_q == 3'd0) begin
          tx_sr_d = prefetch_q;
          addr_d  = addr_q + ADDR_W'(1);
        end else begin
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_sr_q    <= 8'h00;
      tx_sr_q    <= 8'h00;
      prefetch_q <= 8'h00;
      rd_q       <= 1'b0;
      rd_dly_q   <= 1'b0;
      upload_q   <= 1'b0;
      index_q    <= 8'h00;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      prefetch_q <= prefetch_d;
      rd_q       <= rd_d;
      rd_dly_q   <= rd_dly_d;
      upload_q   <= upload_d;
      index_q    <= index_d;
      addr_q     <= addr_d;
    end
  end

  assign spi_do             = tx_sr_q[7];
  assign spi_do_oe          = (state_q == StTx);
  assign ioctl.ioctl_upload = upload_q;
  assign ioctl.ioctl_index  = index_q;
  assign ioctl.ioctl_addr   = addr_q;
  assign ioctl.ioctl_rd     = rd_q;

endmodule
